// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm time entry block.
//   - state_e        : entry FSM state encoding
//   - *_MAX          : per-digit upper bounds for BCD wrap
//   - MASK_*         : blink_mask bit index of each digit
//   - wrap_step4     : wrap-around increment/decrement of a 4-bit BCD digit
package alarm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEHr1,
    StEHr0,
    StEMin1,
    StEMin0
  } state_e;

  localparam logic [1:0] HR1_MAX       = 2'd2;
  localparam logic [3:0] HR0_MAX       = 4'd9;
  localparam logic [3:0] HR0_MAX_AT_20 = 4'd3;
  localparam logic [2:0] MIN1_MAX      = 3'd5;
  localparam logic [3:0] MIN0_MAX      = 4'd9;

  localparam int unsigned MASK_HR1  = 3;
  localparam int unsigned MASK_HR0  = 2;
  localparam int unsigned MASK_MIN1 = 1;
  localparam int unsigned MASK_MIN0 = 0;

  // Step a digit up or down inside 0..max, wrapping at both ends.
  function automatic logic [3:0] wrap_step4(input logic [3:0] val, input logic [3:0] max,
                                            input logic up);
    if (up) return (val >= max) ? 4'd0 : val + 4'd1;
    else    return (val == 4'd0) ? max : val - 4'd1;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// btn_cond: conditions one raw push-button into a single-cycle press pulse.
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high (button reads as released)
//   i_btn   in  raw asynchronous button, active-high
//   o_press out one-cycle pulse per accepted press
// Path: 2-flop synchronizer -> debounce counter -> rising-edge pulse.
module btn_cond #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic        r_press;
  logic [19:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts it, so bounce shorter than DEB_CYCLES is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= DEB_CYCLES - 20'd1) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/alarm_time_entry.sv
// alarm_time_entry: push-button HH:MM alarm entry with atomic commit.
//   clk, rst                 clock, asynchronous active-high reset
//   btn_mode/inc/dec         raw asynchronous buttons, active-high
//   alarm_hr1..alarm_min0    committed alarm digits (BCD)
//   alarm_load               one-cycle strobe on commit
//   editing                  high while an edit state is active
//   edit_hr1..edit_min0      shadow digits being edited
//   blink_mask               bit3=hr1 .. bit0=min0, selected digit blinks
// Optional: define ALARM_EDIT_TIMEOUT_EN to abort an idle edit after TIMEOUT_CYCLES.
module alarm_time_entry
  import alarm_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES     = 20'd1_000_000,
  parameter logic [24:0] BLINK_CYCLES   = 25'd12_500_000,
  parameter logic [27:0] TIMEOUT_CYCLES = 28'd250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [1:0] alarm_hr1,
  output logic [3:0] alarm_hr0,
  output logic [2:0] alarm_min1,
  output logic [3:0] alarm_min0,
  output logic       alarm_load,
  output logic       editing,
  output logic [1:0] edit_hr1,
  output logic [3:0] edit_hr0,
  output logic [2:0] edit_min1,
  output logic [3:0] edit_min0,
  output logic [3:0] blink_mask
);

  logic w_p_mode, w_p_inc, w_p_dec;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_mode (.clk(clk), .rst(rst), .i_btn(btn_mode), .o_press(w_p_mode));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_inc  (.clk(clk), .rst(rst), .i_btn(btn_inc),  .o_press(w_p_inc));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_dec  (.clk(clk), .rst(rst), .i_btn(btn_dec),  .o_press(w_p_dec));

  state_e     r_state, w_state_next;
  logic [1:0] r_alarm_hr1, r_sh_hr1, w_sh_hr1;
  logic [3:0] r_alarm_hr0, r_sh_hr0, w_sh_hr0;
  logic [2:0] r_alarm_min1, r_sh_min1, w_sh_min1;
  logic [3:0] r_alarm_min0, r_sh_min0, w_sh_min0;
  logic       r_load, w_commit, w_inc, w_dec, w_timeout;
  logic [3:0] w_hr0_max;
  logic [24:0] r_blink_cnt;
  logic        r_phase;

`ifdef ALARM_EDIT_TIMEOUT_EN
  logic [27:0] r_to_cnt;
  logic        w_any_press;

  assign w_any_press = w_p_mode | w_p_inc | w_p_dec;
  assign w_timeout   = (r_state != StIdle) && !w_any_press &&
                       (r_to_cnt >= TIMEOUT_CYCLES - 28'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == StIdle || w_any_press || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 28'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Mode wins over inc/dec; simultaneous inc+dec cancel each other.
  assign w_inc = w_p_inc & ~w_p_dec & ~w_p_mode;
  assign w_dec = w_p_dec & ~w_p_inc & ~w_p_mode;

  always_comb begin
    w_state_next = r_state;
    w_sh_hr1     = r_sh_hr1;
    w_sh_hr0     = r_sh_hr0;
    w_sh_min1    = r_sh_min1;
    w_sh_min0    = r_sh_min0;
    w_commit     = 1'b0;
    w_hr0_max    = (r_sh_hr1 == HR1_MAX) ? HR0_MAX_AT_20 : HR0_MAX;
    unique case (r_state)
      StIdle: begin
        if (w_p_mode) begin
          w_state_next = StEHr1;
          w_sh_hr1     = r_alarm_hr1;
          w_sh_hr0     = r_alarm_hr0;
          w_sh_min1    = r_alarm_min1;
          w_sh_min0    = r_alarm_min0;
        end
      end
      StEHr1: begin
        if (w_p_mode)   w_state_next = StEHr0;
        else if (w_inc) w_sh_hr1 = (r_sh_hr1 == HR1_MAX) ? 2'd0 : r_sh_hr1 + 2'd1;
        else if (w_dec) w_sh_hr1 = (r_sh_hr1 == 2'd0) ? HR1_MAX : r_sh_hr1 - 2'd1;
      end
      StEHr0: begin
        if (w_p_mode)            w_state_next = StEMin1;
        else if (w_inc || w_dec) w_sh_hr0 = wrap_step4(r_sh_hr0, w_hr0_max, w_inc);
      end
      StEMin1: begin
        if (w_p_mode)   w_state_next = StEMin0;
        else if (w_inc) w_sh_min1 = (r_sh_min1 >= MIN1_MAX) ? 3'd0 : r_sh_min1 + 3'd1;
        else if (w_dec) w_sh_min1 = (r_sh_min1 == 3'd0) ? MIN1_MAX : r_sh_min1 - 3'd1;
      end
      StEMin0: begin
        if (w_p_mode) begin
          w_state_next = StIdle;
          w_commit     = 1'b1;
        end else if (w_inc || w_dec) begin
          w_sh_min0 = wrap_step4(r_sh_min0, MIN0_MAX, w_inc);
        end
      end
      default: w_state_next = StIdle;
    endcase
    // Keep the shadow a legal time when hr1 becomes 2.
    if (w_sh_hr1 == HR1_MAX && w_sh_hr0 > HR0_MAX_AT_20) w_sh_hr0 = HR0_MAX_AT_20;
    if (w_timeout) begin
      w_state_next = StIdle;
      w_sh_hr1     = r_alarm_hr1;
      w_sh_hr0     = r_alarm_hr0;
      w_sh_min1    = r_alarm_min1;
      w_sh_min0    = r_alarm_min0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_alarm_hr1  <= '0;
      r_alarm_hr0  <= '0;
      r_alarm_min1 <= '0;
      r_alarm_min0 <= '0;
      r_sh_hr1     <= '0;
      r_sh_hr0     <= '0;
      r_sh_min1    <= '0;
      r_sh_min0    <= '0;
      r_load       <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sh_hr1  <= w_sh_hr1;
      r_sh_hr0  <= w_sh_hr0;
      r_sh_min1 <= w_sh_min1;
      r_sh_min0 <= w_sh_min0;
      r_load    <= w_commit;
      if (w_commit) begin
        r_alarm_hr1  <= r_sh_hr1;
        r_alarm_hr0  <= r_sh_hr0;
        r_alarm_min1 <= r_sh_min1;
        r_alarm_min0 <= r_sh_min0;
      end
    end
  end

  // Blink phase restarts high whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_state_next != r_state) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_state != StIdle) begin
      if (r_blink_cnt >= BLINK_CYCLES - 25'd1) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 25'd1;
      end
    end
  end

  always_comb begin
    blink_mask = 4'b0000;
    unique case (r_state)
      StEHr1:  blink_mask[MASK_HR1]  = r_phase;
      StEHr0:  blink_mask[MASK_HR0]  = r_phase;
      StEMin1: blink_mask[MASK_MIN1] = r_phase;
      StEMin0: blink_mask[MASK_MIN0] = r_phase;
      default: blink_mask = 4'b0000;
    endcase
  end

  assign alarm_hr1  = r_alarm_hr1;
  assign alarm_hr0  = r_alarm_hr0;
  assign alarm_min1 = r_alarm_min1;
  assign alarm_min0 = r_alarm_min0;
  assign alarm_load = r_load;
  assign editing    = (r_state != StIdle);
  assign edit_hr1   = r_sh_hr1;
  assign edit_hr0   = r_sh_hr0;
  assign edit_min1  = r_sh_min1;
  assign edit_min0  = r_sh_min0;

endmodule

// File: tb/tb_alarm_time_entry.sv
// tb_alarm_time_entry: directed bench for alarm_time_entry with short timing parameters.
module tb_alarm_time_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [1:0] alarm_hr1, edit_hr1;
  logic [3:0] alarm_hr0, edit_hr0;
  logic [2:0] alarm_min1, edit_min1;
  logic [3:0] alarm_min0, edit_min0;
  logic       alarm_load, editing;
  logic [3:0] blink_mask;

  int checks = 0;
  int errors = 0;
  int load_count = 0;
  bit found;

  alarm_time_entry #(
    .DEB_CYCLES    (20'd4),
    .BLINK_CYCLES  (25'd8),
    .TIMEOUT_CYCLES(28'd300)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .alarm_hr1 (alarm_hr1),
    .alarm_hr0 (alarm_hr0),
    .alarm_min1(alarm_min1),
    .alarm_min0(alarm_min0),
    .alarm_load(alarm_load),
    .editing   (editing),
    .edit_hr1  (edit_hr1),
    .edit_hr0  (edit_hr0),
    .edit_min1 (edit_min1),
    .edit_min0 (edit_min0),
    .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alarm_load === 1'b1) load_count++;

  function automatic logic [31:0] hhmm(input int h1, input int h0, input int m1, input int m0);
    return (h1 << 12) | (h0 << 8) | (m1 << 4) | m0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    @(negedge clk);
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (12) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [31:0] alarm_v();
    return hhmm(alarm_hr1, alarm_hr0, alarm_min1, alarm_min0);
  endfunction

  function automatic logic [31:0] edit_v();
    return hhmm(edit_hr1, edit_hr0, edit_min1, edit_min0);
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_alarm", alarm_v(), hhmm(0, 0, 0, 0));
    check("reset_edit", edit_v(), hhmm(0, 0, 0, 0));
    check("reset_editing", editing, 0);
    check("reset_blink", blink_mask, 4'b0000);
    check("reset_load", load_count, 0);

    // First entry: watch blink phase from the first edit cycle.
    @(negedge clk);
    btn_mode = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (editing === 1'b1) found = 1'b1;
    end
    check("enter_edit", found, 1);
    check("blink_entry", blink_mask, 4'b1000);
    repeat (7) @(negedge clk);
    check("blink_hold", blink_mask, 4'b1000);
    @(negedge clk);
    check("blink_toggle", blink_mask, 4'b0000);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);

    repeat (2) press(0, 1, 0);
    check("hr1_inc2", edit_hr1, 2);
    press(1, 0, 0);
    repeat (3) press(0, 1, 0);
    press(1, 0, 0);
    repeat (4) press(0, 1, 0);
    press(1, 0, 0);
    repeat (5) press(0, 1, 0);
    check("shadow_2345", edit_v(), hhmm(2, 3, 4, 5));
    check("alarm_held", alarm_v(), hhmm(0, 0, 0, 0));
    check("no_early_load", load_count, 0);
    press(1, 0, 0);
    check("commit_2345", alarm_v(), hhmm(2, 3, 4, 5));
    check("load_once", load_count, 1);
    check("idle_editing", editing, 0);
    check("idle_blink", blink_mask, 4'b0000);

    // Wrap behaviour.
    press(1, 0, 0);
    check("shadow_copy", edit_v(), hhmm(2, 3, 4, 5));
    press(0, 0, 1);
    check("hr1_dec", edit_hr1, 1);
    press(1, 0, 0);
    repeat (4) press(0, 0, 1);
    check("hr0_dec_wrap", edit_hr0, 9);
    press(1, 0, 0);
    press(0, 1, 0);
    check("min1_to5", edit_min1, 5);
    press(0, 1, 0);
    check("min1_wrap", edit_min1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("commit_1905", alarm_v(), hhmm(1, 9, 0, 5));
    check("load_twice", load_count, 2);

    press(1, 0, 0);
    press(0, 1, 0);
    check("hr1_clamp", edit_v(), hhmm(2, 3, 0, 5));
    press(0, 0, 1);
    press(0, 0, 1);
    check("hr1_zero", edit_hr1, 0);
    press(0, 0, 1);
    check("hr1_dec_wrap", edit_v(), hhmm(2, 3, 0, 5));
    press(0, 1, 1);
    check("inc_dec_cancel", edit_v(), hhmm(2, 3, 0, 5));
    press(1, 1, 0);
    check("mode_inc_digit", edit_v(), hhmm(2, 3, 0, 5));
    press(0, 1, 0);
    check("hr0_wrap_at_20", edit_v(), hhmm(2, 0, 0, 5));

    // Bounce shorter than the debounce window, then a clean press.
    repeat (10) begin
      @(negedge clk); btn_inc = 1'b1;
      @(negedge clk);
      @(negedge clk); btn_inc = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("bounce_ignored", edit_hr0, 0);
    press(0, 1, 0);
    check("bounce_one_inc", edit_hr0, 1);
    check("alarm_unchanged", alarm_v(), hhmm(1, 9, 0, 5));
    repeat (3) press(1, 0, 0);
    check("commit_2105", alarm_v(), hhmm(2, 1, 0, 5));
    check("load_three", load_count, 3);

`ifdef ALARM_EDIT_TIMEOUT_EN
    press(1, 0, 0);
    press(0, 1, 0);
    check("to_shadow", edit_hr1, 0);
    repeat (400) @(negedge clk);
    check("to_idle", editing, 0);
    check("to_alarm", alarm_v(), hhmm(2, 1, 0, 5));
    check("to_no_load", load_count, 3);
`endif

    // Reset in the middle of an edit.
    press(1, 0, 0);
    press(0, 1, 0);
    check("pre_rst_edit", editing, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alarm", alarm_v(), hhmm(0, 0, 0, 0));
    check("rst_edit", edit_v(), hhmm(0, 0, 0, 0));
    check("rst_editing", editing, 0);
    check("rst_no_load", load_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
